// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand request side and result response side.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output in_valid, minuend, subtrahend, out_ready,
    input  in_ready, out_valid, difference, borrow_out, overflow
  );

  modport slave (
    input  in_valid, minuend, subtrahend, out_ready,
    output in_ready, out_valid, difference, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor (a + ~b + 1, DIGIT bits per clock).
// Define SAT_EN to clamp the difference on signed overflow instead of wrapping.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SUM_W = DIGIT + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] nb_q,     nb_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q,    ovf_d;

  logic [SUM_W-1:0] sum;
  logic             ovf_w;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    ovf_w    = 1'b0;
    sum      = SUM_W'({1'b0, a_q[DIGIT-1:0]}) + SUM_W'({1'b0, nb_q[DIGIT-1:0]})
             + SUM_W'(carry_q);

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.minuend;
          nb_d    = ~bus.subtrahend;
          carry_d = 1'b1;
          cnt_d   = '0;
          a_msb_d = bus.minuend[WIDTH-1];
          b_msb_d = bus.subtrahend[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        carry_d = sum[DIGIT];
        a_d     = a_q >> DIGIT;
        nb_d    = nb_q >> DIGIT;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          // Operands differ in sign and the result sign disagrees with a
          ovf_w    = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
          ovf_d    = ovf_w;
          borrow_d = ~sum[DIGIT];
`ifdef SAT_EN
          if (ovf_w) begin
            diff_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            diff_d = res_d;
          end
`else
          diff_d = res_d;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      nb_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.difference = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: arithmetic reference model, random and directed operands.
module tb_serial_subtractor;

  localparam int unsigned W    = 32;
  localparam int unsigned NDIG = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  exp_t sb_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   m;
    longint t;
    t        = longint'($signed(a)) - longint'($signed(b));
    m.diff   = a - b;
    m.borrow = (a < b);
    m.ovf    = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef SAT_EN
    if (m.ovf) m.diff = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return m;
  endfunction

  // Monitor: pop and compare on every output handshake; check latency at out_valid rise
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_ov <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov)
        chk("latency", W'(cyc - acc_cyc), W'(NDIG));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("difference", bus.difference, e.diff);
          chk("borrow_out", W'(bus.borrow_out), W'(e.borrow));
          chk("overflow", W'(bus.overflow), W'(e.ovf));
        end
      end
      prev_ov <= bus.out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.minuend    = a;
    bus.subtrahend = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      sb_q.push_back(model(a, b));
      acc_cyc = cyc + 1;
      @(posedge clk); #1;
    end else begin
      chk("accept_timeout", 32'd1, 32'd0);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", W'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   W'(bus.in_ready),   32'd1);
    chk({tag, "_out_valid"},  W'(bus.out_valid),  32'd0);
    chk({tag, "_difference"}, bus.difference,     32'd0);
    chk({tag, "_borrow"},     W'(bus.borrow_out), 32'd0);
    chk({tag, "_overflow"},   W'(bus.overflow),   32'd0);
  endtask

  initial begin
    logic [W-1:0] pick [5];
    logic [W-1:0] a, b;
    int n;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.minuend    = '0;
    bus.subtrahend = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Directed cases, including sign and boundary corners
    send(32'd100, 32'd58);
    send(32'd5, 32'd7);
    send(32'h8000_0000, 32'd1);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    send(32'h1234_5678, 32'd0);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    send(32'd5, 32'h8000_0000);
    send(32'd0, 32'h8000_0000);
    send(32'h8000_0000, 32'h8000_0000);
    drain();

    // Stall in DONE with a new request pending
    ready_mode = 2;
    send(32'd11, 32'd3);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", W'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.minuend    = 32'd20;
    bus.subtrahend = 32'd4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_in_ready", W'(bus.in_ready), 32'd0);
      chk("stall_out_valid", W'(bus.out_valid), 32'd1);
      chk("stall_difference", bus.difference, 32'd8);
    end
    ready_mode = 0;
    send(32'd20, 32'd4);
    drain();

    // Random operands with random backpressure
    pick[0] = 32'h0000_0000;
    pick[1] = 32'h8000_0000;
    pick[2] = 32'h7FFF_FFFF;
    pick[3] = 32'hFFFF_FFFF;
    pick[4] = 32'h0000_0001;
    ready_mode = 1;
    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) a = pick[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) b = pick[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) b = a;
      send(a, b);
    end
    ready_mode = 0;
    drain();

    // Reset at RUN digit 3 drops the in-flight operation
    send(32'd123, 32'd45);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrun_reset");
    send(32'd1, 32'd1);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
